// File: rtl/console_dma_master_if.sv
// Bus-side interface of the console DMA master: E/Q phase clocks, BA/BS grant,
// address/data buses with separate drive enables (the tristate is in the top level).
interface console_dma_master_if;
    logic        e;
    logic        q;
    logic        bus_available;
    logic        bus_status;
    logic [7:0]  data_in;
    logic        n_breq;
    logic [15:0] address_out;
    logic        addr_oe;
    logic        r_nw;
    logic [7:0]  data_out;
    logic        data_oe;

    modport master (
        input  e, q, bus_available, bus_status, data_in,
        output n_breq, address_out, addr_oe, r_nw, data_out, data_oe
    );

    modport slave (
        output e, q, bus_available, bus_status, data_in,
        input  n_breq, address_out, addr_oe, r_nw, data_out, data_oe
    );
endinterface

// File: rtl/console_dma_master.sv
// Block-copy DMA master that steals the CPU bus via BREQ and runs read/write cycle pairs.
// Define CONSOLE_DMA_BURST_LIMIT_EN to hand the bus back for one E period every 14 bus cycles.
module console_dma_master (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        start,
    input  logic [15:0]                 src_addr,
    input  logic [15:0]                 dst_addr,
    input  logic [7:0]                  length,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    console_dma_master_if.master        bus
);

    typedef enum logic [2:0] {IDLE, REQ, RD, WR, RELEASE} state_t;

    state_t      state, state_n;
    logic        e_q, q_q;
    logic        e_fall, q_rise, grant, abort;
    logic [15:0] src, src_n, dst, dst_n;
    logic [8:0]  count, count_n, count_dec;
    logic [7:0]  hold, hold_n;
    logic        drop, drop_n, drop_addr, drop_addr_n;
    logic        n_breq_n, addr_oe_n, r_nw_n, data_oe_n;
    logic [15:0] address_n;
    logic [7:0]  data_out_n;
    logic        busy_n, done_n, err_n;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
    localparam logic [3:0] BURST_MAX = 4'd14;
    logic [3:0]  burst, burst_n;
`endif

    assign e_fall    = e_q & ~bus.e;
    assign q_rise    = ~q_q & bus.q;
    assign grant     = bus.bus_available & bus.bus_status;
    assign abort     = e_fall & ~grant & ((state == RD) | (state == WR));
    assign count_dec = count - 9'd1;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path through the case can infer a latch.
        state_n     = state;
        src_n       = src;
        dst_n       = dst;
        count_n     = count;
        hold_n      = hold;
        n_breq_n    = bus.n_breq;
        addr_oe_n   = bus.addr_oe;
        r_nw_n      = bus.r_nw;
        data_oe_n   = bus.data_oe;
        address_n   = bus.address_out;
        data_out_n  = bus.data_out;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = err;
        drop_n      = 1'b0;
        drop_addr_n = 1'b0;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
        burst_n     = burst;
`endif

        // Write data is held one clk past the E fall; the address goes with it if the bus is handed back.
        if (drop) begin
            data_oe_n = 1'b0;
            if (drop_addr) begin
                addr_oe_n = 1'b0;
                r_nw_n    = 1'b1;
            end
        end

        if (abort) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            err_n     = 1'b1;
            n_breq_n  = 1'b1;
            addr_oe_n = 1'b0;
            data_oe_n = 1'b0;
            r_nw_n    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state_n  = REQ;
                        busy_n   = 1'b1;
                        err_n    = 1'b0;
                        n_breq_n = 1'b0;
                        src_n    = src_addr;
                        dst_n    = dst_addr;
                        count_n  = (length == 8'd0) ? 9'd256 : {1'b0, length};
                    end
                end
                REQ: begin
                    if (e_fall && grant) begin
                        state_n = RD;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
                        burst_n = '0;
`endif
                    end
                end
                RD: begin
                    if (e_fall) begin
                        hold_n  = bus.data_in;
                        src_n   = src + 16'd1;
                        state_n = WR;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
                        burst_n = burst + 4'd1;
`endif
                    end else if (q_rise) begin
                        address_n = src;
                        r_nw_n    = 1'b1;
                        addr_oe_n = 1'b1;
                    end
                end
                WR: begin
                    if (e_fall) begin
                        dst_n   = dst + 16'd1;
                        count_n = count_dec;
                        drop_n  = 1'b1;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
                        burst_n = burst + 4'd1;
`endif
                        if (count_dec == 9'd0) begin
                            state_n     = IDLE;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            n_breq_n    = 1'b1;
                            drop_addr_n = 1'b1;
                        end
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
                        else if (burst_n == BURST_MAX) begin
                            state_n     = RELEASE;
                            n_breq_n    = 1'b1;
                            drop_addr_n = 1'b1;
                        end
`endif
                        else begin
                            state_n = RD;
                        end
                    end else if (q_rise) begin
                        address_n  = dst;
                        r_nw_n     = 1'b0;
                        data_out_n = hold;
                        data_oe_n  = 1'b1;
                    end
                end
                RELEASE: begin
                    if (e_fall) begin
                        state_n  = REQ;
                        n_breq_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            e_q             <= 1'b0;
            q_q             <= 1'b0;
            src             <= '0;
            dst             <= '0;
            count           <= '0;
            hold            <= '0;
            drop            <= 1'b0;
            drop_addr       <= 1'b0;
            bus.n_breq      <= 1'b1;
            bus.addr_oe     <= 1'b0;
            bus.r_nw        <= 1'b1;
            bus.data_oe     <= 1'b0;
            bus.address_out <= '0;
            bus.data_out    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
            burst           <= '0;
`endif
        end else begin
            state           <= state_n;
            e_q             <= bus.e;
            q_q             <= bus.q;
            src             <= src_n;
            dst             <= dst_n;
            count           <= count_n;
            hold            <= hold_n;
            drop            <= drop_n;
            drop_addr       <= drop_addr_n;
            bus.n_breq      <= n_breq_n;
            bus.addr_oe     <= addr_oe_n;
            bus.r_nw        <= r_nw_n;
            bus.data_oe     <= data_oe_n;
            bus.address_out <= address_n;
            bus.data_out    <= data_out_n;
            busy            <= busy_n;
            done            <= done_n;
            err             <= err_n;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
            burst           <= burst_n;
`endif
        end
    end

endmodule

// File: tb/tb_console_dma_master.sv
// Directed self-checking bench for console_dma_master: generates E/Q phases, models memory
// reads, logs every bus cycle at E fall and checks copies, aborts, resets and burst release.
module tb_console_dma_master;

    logic        clk;
    logic        n_reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        err;

    console_dma_master_if bus ();

    console_dma_master dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    int n_pass;
    int n_total;
    int done_cnt, rel_clks, rel_first, doe_clks, aoe_clks, ncyc, wr_no_oe;
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  wd_q[$];
    bit          use_fixed;
    logic [7:0]  fixed_val;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] + (a[15:8] * 8'd3) + 8'h11;
    endfunction

    assign bus.data_in = use_fixed ? fixed_val : pat(bus.address_out);

    function automatic logic [15:0] rd_at(input int i);
        return (i < rd_q.size()) ? rd_q[i] : 16'hxxxx;
    endfunction
    function automatic logic [15:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
    endfunction
    function automatic logic [7:0] wd_at(input int i);
        return (i < wd_q.size()) ? wd_q[i] : 8'hxx;
    endfunction

    function automatic logic [31:0] outs();
        return {bus.n_breq, bus.addr_oe, bus.data_oe, bus.r_nw, busy, done, err, 1'b0,
                bus.address_out, bus.data_out};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // E/Q phases: q high in phases 0-1, e high in phases 1-2; bus cycles are logged at E fall.
    initial begin
        int phase;
        phase = 3;
        bus.e = 1'b0;
        bus.q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 4;
            if (phase == 3 && bus.addr_oe === 1'b1) begin
                ncyc++;
                if (bus.r_nw === 1'b1) begin
                    rd_q.push_back(bus.address_out);
                end else begin
                    wr_q.push_back(bus.address_out);
                    wd_q.push_back(bus.data_out);
                    if (bus.data_oe !== 1'b1) wr_no_oe++;
                end
            end
            bus.q = (phase == 0) || (phase == 1);
            bus.e = (phase == 1) || (phase == 2);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1 && bus.n_breq === 1'b1) begin
                rel_clks++;
                if (rel_first < 0) rel_first = ncyc;
            end
            if (bus.data_oe === 1'b1) doe_clks++;
            if (bus.addr_oe === 1'b1) aoe_clks++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        wd_q.delete();
        done_cnt  = 0;
        rel_clks  = 0;
        rel_first = -1;
        doe_clks  = 0;
        aoe_clks  = 0;
        ncyc      = 0;
        wr_no_oe  = 0;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL %s_done_timeout: done=%b after %0d clks, required 1", tag, done, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        tick(2);
        n_total++;
        if (outs() !== 32'h9000_0000) $display("FAIL reset_outputs: got %h, required 90000000", outs());
        else n_pass++;
        n_total++;
        if (bus.n_breq !== 1'b1) $display("FAIL reset_n_breq: got %b, required 1", bus.n_breq);
        else n_pass++;
        n_total++;
        if (bus.r_nw !== 1'b1) $display("FAIL reset_r_nw: got %b, required 1", bus.r_nw);
        else n_pass++;
        n_reset = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        clear_logs();
        use_fixed = 1'b1;
        fixed_val = 8'hA5;
        do_start(16'h1000, 16'h2000, 8'd1);
        n_total++;
        if ({busy, bus.n_breq, err} !== 3'b100) $display("FAIL single_accept: busy,n_breq,err=%b, required 100", {busy, bus.n_breq, err});
        else n_pass++;
        wait_done(100, "single");
        n_total++;
        if ({bus.data_oe, bus.addr_oe} !== 2'b11) $display("FAIL single_oe_hold: data_oe,addr_oe=%b, required 11", {bus.data_oe, bus.addr_oe});
        else n_pass++;
        // A start on the done clock must not launch a new copy.
        src_addr = 16'h7777;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
        n_total++;
        if ({busy, bus.n_breq, bus.addr_oe, bus.data_oe, bus.r_nw} !== 5'b01001)
            $display("FAIL single_after_done: busy,n_breq,addr_oe,data_oe,r_nw=%b, required 01001",
                     {busy, bus.n_breq, bus.addr_oe, bus.data_oe, bus.r_nw});
        else n_pass++;
        tick(4);
        n_total++;
        if (rd_q.size() != 1 || rd_at(0) !== 16'h1000) $display("FAIL single_read: n=%0d addr=%h, required 1 at 1000", rd_q.size(), rd_at(0));
        else n_pass++;
        n_total++;
        if (wr_q.size() != 1 || wr_at(0) !== 16'h2000 || wd_at(0) !== 8'hA5)
            $display("FAIL single_write: n=%0d addr=%h data=%h, required 1 at 2000 data a5", wr_q.size(), wr_at(0), wd_at(0));
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || err !== 1'b0) $display("FAIL single_done: pulses=%0d err=%b, required 1 and 0", done_cnt, err);
        else n_pass++;
        n_total++;
        if (doe_clks != 4 || aoe_clks != 8 || wr_no_oe != 0)
            $display("FAIL single_oe_clks: data_oe=%0d addr_oe=%0d bad_wr=%0d, required 4 8 0", doe_clks, aoe_clks, wr_no_oe);
        else n_pass++;
        use_fixed = 1'b0;
    endtask

    task automatic test_wrap();
        clear_logs();
        do_start(16'hFFFF, 16'h3000, 8'd2);
        wait_done(100, "wrap");
        tick(2);
        n_total++;
        if (rd_q.size() != 2 || rd_at(0) !== 16'hFFFF || rd_at(1) !== 16'h0000)
            $display("FAIL wrap_reads: n=%0d %h %h, required 2 ffff 0000", rd_q.size(), rd_at(0), rd_at(1));
        else n_pass++;
        n_total++;
        if (wr_at(0) !== 16'h3000 || wr_at(1) !== 16'h3001 || wd_at(0) !== pat(16'hFFFF) || wd_at(1) !== pat(16'h0000))
            $display("FAIL wrap_writes: %h/%h %h/%h, required 3000/%h 3001/%h",
                     wr_at(0), wd_at(0), wr_at(1), wd_at(1), pat(16'hFFFF), pat(16'h0000));
        else n_pass++;
    endtask

    task automatic test_len256();
        int errs;
        clear_logs();
        do_start(16'h1000, 16'h2000, 8'd0);
        wait_done(4000, "len256");
        tick(2);
        n_total++;
        if (rd_q.size() != 256 || wr_q.size() != 256) $display("FAIL len256_count: rd=%0d wr=%0d, required 256 256", rd_q.size(), wr_q.size());
        else n_pass++;
        n_total++;
        if (rd_at(255) + 16'd1 !== 16'h1100 || wr_at(255) + 16'd1 !== 16'h2100)
            $display("FAIL len256_final: next src=%h dst=%h, required 1100 2100", rd_at(255) + 16'd1, wr_at(255) + 16'd1);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (rd_at(i) !== 16'h1000 + 16'(i) || wr_at(i) !== 16'h2000 + 16'(i) || wd_at(i) !== pat(16'h1000 + 16'(i))) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL len256_data: %0d bad copies, required 0", errs);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || err !== 1'b0) $display("FAIL len256_done: pulses=%0d err=%b, required 1 and 0", done_cnt, err);
        else n_pass++;
    endtask

    task automatic test_burst();
        int errs;
        int exp_first;
        int exp_rel;
`ifdef CONSOLE_DMA_BURST_LIMIT_EN
        exp_first = 14;
        exp_rel   = 4;
`else
        exp_first = -1;
        exp_rel   = 0;
`endif
        clear_logs();
        do_start(16'h4000, 16'h5000, 8'd10);
        wait_done(400, "burst");
        tick(2);
        n_total++;
        if (ncyc != 20) $display("FAIL burst_cycles: got %0d, required 20", ncyc);
        else n_pass++;
        n_total++;
        if (rel_first != exp_first || rel_clks != exp_rel)
            $display("FAIL burst_release: after cycle %0d for %0d clks, required %0d %0d", rel_first, rel_clks, exp_first, exp_rel);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_at(i) !== 16'h4000 + 16'(i) || wr_at(i) !== 16'h5000 + 16'(i) || wd_at(i) !== pat(16'h4000 + 16'(i))) errs++;
        end
        n_total++;
        if (errs != 0 || done_cnt != 1) $display("FAIL burst_data: bad=%0d pulses=%0d, required 0 1", errs, done_cnt);
        else n_pass++;
    endtask

    task automatic test_abort();
        int n;
        clear_logs();
        do_start(16'h6000, 16'h7000, 8'd5);
        n = 0;
        while (ncyc < 2 && n < 100) begin
            tick(1);
            n++;
        end
        n_total++;
        if (ncyc < 2) $display("FAIL abort_wait: cycles=%0d, required 2", ncyc);
        else n_pass++;
        // Third cycle (second read) has had its q rise; grant goes away before its E fall.
        tick(2);
        bus.bus_available = 1'b0;
        wait_done(40, "abort");
        n_total++;
        if ({err, busy, bus.n_breq, bus.addr_oe, bus.data_oe} !== 5'b10100)
            $display("FAIL abort_outputs: err,busy,n_breq,addr_oe,data_oe=%b, required 10100",
                     {err, busy, bus.n_breq, bus.addr_oe, bus.data_oe});
        else n_pass++;
        tick(2);
        n_total++;
        if (done_cnt != 1 || wr_q.size() != 1 || err !== 1'b1)
            $display("FAIL abort_after: pulses=%0d writes=%0d err=%b, required 1 1 1", done_cnt, wr_q.size(), err);
        else n_pass++;
        bus.bus_available = 1'b1;
        do_start(16'h8000, 16'h9000, 8'd1);
        n_total++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL abort_err_clear: err=%b busy=%b, required 0 1", err, busy);
        else n_pass++;
        wait_done(100, "abort_next");
        tick(2);
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        do_start(16'hA000, 16'hB000, 8'd4);
        n = 0;
        while (bus.data_oe !== 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        n_total++;
        if (bus.data_oe !== 1'b1) $display("FAIL mid_wait: data_oe=%b, required 1", bus.data_oe);
        else n_pass++;
        n_reset = 1'b0;
        #1;
        n_total++;
        if (outs() !== 32'h9000_0000) $display("FAIL mid_reset_async: got %h, required 90000000", outs());
        else n_pass++;
        tick(3);
        n_total++;
        if (done_cnt != 0 || busy !== 1'b0) $display("FAIL mid_no_done: pulses=%0d busy=%b, required 0 0", done_cnt, busy);
        else n_pass++;
        clear_logs();
        src_addr = 16'hC000;
        dst_addr = 16'hD000;
        length   = 8'd1;
        start    = 1'b1;
        n_reset  = 1'b1;
        tick(1);
        start    = 1'b0;
        n_total++;
        if (busy !== 1'b1 || bus.n_breq !== 1'b0) $display("FAIL mid_first_start: busy=%b n_breq=%b, required 1 0", busy, bus.n_breq);
        else n_pass++;
        wait_done(100, "mid");
        tick(2);
        n_total++;
        if (rd_at(0) !== 16'hC000 || wr_at(0) !== 16'hD000 || done_cnt != 1)
            $display("FAIL mid_copy: rd=%h wr=%h pulses=%0d, required c000 d000 1", rd_at(0), wr_at(0), done_cnt);
        else n_pass++;
    endtask

    initial begin
        n_pass            = 0;
        n_total           = 0;
        start             = 1'b0;
        src_addr          = '0;
        dst_addr          = '0;
        length            = '0;
        n_reset           = 1'b0;
        use_fixed         = 1'b0;
        fixed_val         = '0;
        bus.bus_available = 1'b1;
        bus.bus_status    = 1'b1;
        clear_logs();
        test_reset();
        test_single();
        test_wrap();
        test_len256();
        test_burst();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/console_dma_master.md
CONSOLE_DMA_MASTER -- requirements
Module: console_dma_master

Interface
REQ-001 SHALL: clk  input  1  system clock; e and q are synchronous to it, 4 clk periods per E period.
REQ-002 SHALL: n_reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  input  1  one-clk pulse that begins a block copy; ignored while busy=1.
REQ-004 SHALL: src_addr  input  16  first source address, sampled when start is accepted.
REQ-005 SHALL: dst_addr  input  16  first destination address, sampled when start is accepted.
REQ-006 SHALL: length  input  8  byte count, sampled when start is accepted; 0 means 256.
REQ-007 SHALL: e, q  input  1 each  CPU bus phase clocks; address is valid from q rise and data is latched on e fall.
REQ-008 SHALL: bus_available, bus_status  input  1 each  CPU BA/BS; grant = both 1.
REQ-009 SHALL: data_in  input  8  data bus read value.
REQ-010 SHALL: n_breq  output  1  active-low bus request to the CPU.
REQ-011 SHALL: address_out  output  16, addr_oe  output  1  bus address and its drive enable.
REQ-012 SHALL: r_nw  output  1  1 = read, 0 = write; its value is don't-care-high when addr_oe=0.
REQ-013 SHALL: data_out  output  8, data_oe  output  1  write data and its drive enable; the tristate lives in the top level.
REQ-014 SHALL: busy  output  1, done  output  1 (one-clk pulse), err  output  1 (sticky until next accepted start).

Function
REQ-015 SHALL: internal e_fall = registered e AND NOT e; q_rise = NOT registered q AND q; all bus actions key on these strobes.
REQ-016 SHALL: states are IDLE, REQ, RD, WR, RELEASE.
REQ-017 SHALL: IDLE->REQ on accepted start: busy=1, err=0, n_breq=0, and src/dst/count are loaded.
REQ-018 SHALL: REQ->RD on the first e_fall with grant=1; the RD cycle begins at the next q_rise.
REQ-019 SHALL: RD: at q_rise, address_out=src, r_nw=1, addr_oe=1; at e_fall, hold register=data_in and src=src+1 (mod 2^16); then go to WR.
REQ-020 SHALL: WR: at q_rise, address_out=dst, r_nw=0, data_out=hold, data_oe=1; at e_fall, dst=dst+1 (mod 2^16) and count=count-1.
REQ-021 SHALL: data_oe deasserts one clk after the WR e_fall; addr_oe deasserts at the same time when no further cycle follows.
REQ-022 SHALL: after WR with count=0, go to IDLE: n_breq=1, addr_oe=0, busy=0, done pulses for 1 clk.
REQ-023 SHALL: after WR with count!=0, go back to RD, unless the burst limit applies (REQ-032).
REQ-024 SHALL: grant sampled 0 at any e_fall in RD or WR causes an abort: go to IDLE, set err=1, pulse done, deassert both enables and n_breq on the next clk.
REQ-025 SHALL: start arriving on the same clk as done is ignored.
REQ-026 SHALL: the count register is 9 bits wide so that length 0 yields 256 copies.

Reset
REQ-027 SHALL: n_reset low forces immediately (asynchronously): state IDLE, n_breq=1, addr_oe=0, data_oe=0, r_nw=1, busy=0, done=0, err=0, address_out=0, data_out=0.
REQ-028 SHALL: reset asserted mid-transfer abandons the copy with no done pulse.
REQ-029 SHALL: after reset release, the first start is accepted on the first clk edge.

Configuration
REQ-030 SHALL: the macro is CONSOLE_DMA_BURST_LIMIT_EN.
REQ-031 SHALL: without CONSOLE_DMA_BURST_LIMIT_EN, the bus is held for the entire copy.
REQ-032 SHALL: with CONSOLE_DMA_BURST_LIMIT_EN, after 14 bus cycles in one grant with count!=0, go to RELEASE: n_breq=1 and enables off for exactly one E period (e_fall to e_fall); then go to REQ with n_breq=0; the burst counter clears on each new grant.

Verification
REQ-033 SHALL: src=0x1000, dst=0x2000, length=1, data_in=0xA5 -> read 0x1000, then write 0x2000 with 0xA5; done pulses once; err=0; n_breq=1 after completion.
REQ-034 SHALL: length=0 -> 256 reads and 256 writes, final src=0x1100 and dst=0x2100.
REQ-035 SHALL: src=0xFFFF, length=2 -> reads at 0xFFFF then 0x0000.
REQ-036 SHALL: length=10 with macro -> n_breq high for one E period after the 14th cycle, 20 cycles total; without macro -> n_breq continuously low for 20 cycles.
REQ-037 SHALL: bus_available dropped during the 3rd cycle -> err=1, done pulses once, enables deasserted, n_breq=1.
REQ-038 SHALL: n_reset pulsed during a WR with data_oe=1 -> all outputs take REQ-027 values before the next clk edge.
